// File: rtl/mawb_pkg.sv
// rtl/mawb_pkg.sv - shared widths, selector codes, bundle type and skid-buffer states for mawb_reg
package mawb_pkg;

  localparam int MAWB_WIDTH      = 32;
  localparam int MAWB_REG_ADDR_W = 5;
  localparam int MAWB_SEL_W      = 2;
  localparam int MAWB_W          = 4 * MAWB_WIDTH + MAWB_SEL_W + 1 + MAWB_REG_ADDR_W;

  localparam logic [MAWB_SEL_W-1:0] SEL_RESULT = 2'd0;
  localparam logic [MAWB_SEL_W-1:0] SEL_IMM    = 2'd1;
  localparam logic [MAWB_SEL_W-1:0] SEL_DATA   = 2'd2;
  localparam logic [MAWB_SEL_W-1:0] SEL_ADDR   = 2'd3;

  typedef struct packed {
    logic [MAWB_WIDTH-1:0]      result;
    logic [MAWB_WIDTH-1:0]      imm32;
    logic [MAWB_WIDTH-1:0]      data;
    logic [MAWB_WIDTH-1:0]      addr;
    logic [MAWB_SEL_W-1:0]      sel;
    logic                       regwrite;
    logic [MAWB_REG_ADDR_W-1:0] writereg;
  } mawb_bundle_t;

  // Encoding is {main_v, skid_v}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } skid_state_e;

endpackage

// File: rtl/mawb_reg_if.sv
// rtl/mawb_reg_if.sv - MA-side and WB-side handshake/payload signals of mawb_reg
interface mawb_reg_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
);
  logic                  FlushIn;
  logic                  ValidIn;
  logic                  ReadyOut;
  logic [WIDTH-1:0]      ResultIn;
  logic [WIDTH-1:0]      Imm32In;
  logic [WIDTH-1:0]      DataIn;
  logic [WIDTH-1:0]      AddrIn;
  logic [SEL_W-1:0]      SelectorIn;
  logic                  RegWriteIn;
  logic [REG_ADDR_W-1:0] WriteRegIn;
  logic                  ValidOut;
  logic                  ReadyIn;
  logic [WIDTH-1:0]      ResultOut;
  logic [WIDTH-1:0]      Imm32Out;
  logic [WIDTH-1:0]      DataOut;
  logic [WIDTH-1:0]      AddrOut;
  logic [SEL_W-1:0]      SelectorOut;
  logic [REG_ADDR_W-1:0] WriteRegOut;
  logic                  WbEnOut;
  logic [31:0]           RetiredOut;

  modport master (
    output FlushIn, ValidIn, ResultIn, Imm32In, DataIn, AddrIn, SelectorIn,
           RegWriteIn, WriteRegIn, ReadyIn,
    input  ReadyOut, ValidOut, ResultOut, Imm32Out, DataOut, AddrOut,
           SelectorOut, WriteRegOut, WbEnOut, RetiredOut
  );

  modport slave (
    input  FlushIn, ValidIn, ResultIn, Imm32In, DataIn, AddrIn, SelectorIn,
           RegWriteIn, WriteRegIn, ReadyIn,
    output ReadyOut, ValidOut, ResultOut, Imm32Out, DataOut, AddrOut,
           SelectorOut, WriteRegOut, WbEnOut, RetiredOut
  );
endinterface

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - generic 2-entry skid buffer with registered ready and synchronous flush
module skid_buf2
  import mawb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire;
  logic         out_fire;

  // Ready depends only on state, so downstream stalls never reach MA combinationally.
  assign in_ready_o  = (state_q != ST_TWO);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          state_d = ST_TWO;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/mawb_reg.sv
// rtl/mawb_reg.sv - MA/WB pipeline register: skid-buffered bundle, write strobe, retired counter
module mawb_reg
  import mawb_pkg::*;
#(
  parameter int WIDTH      = MAWB_WIDTH,
  parameter int REG_ADDR_W = MAWB_REG_ADDR_W,
  parameter int SEL_W      = MAWB_SEL_W
) (
  input  logic     clk,
  input  logic     reset,
  mawb_reg_if.slave bus
);

  localparam int PW = 4 * WIDTH + SEL_W + 1 + REG_ADDR_W;

  logic [PW-1:0]         in_flat;
  logic [PW-1:0]         out_flat;
  logic                  head_regwrite;
  logic                  out_fire;
  logic [31:0]           retired_q, retired_d;

  assign in_flat = {bus.ResultIn, bus.Imm32In, bus.DataIn, bus.AddrIn,
                    bus.SelectorIn, bus.RegWriteIn, bus.WriteRegIn};

  skid_buf2 #(
    .W (PW)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.FlushIn),
    .in_valid_i  (bus.ValidIn),
    .in_ready_o  (bus.ReadyOut),
    .in_data_i   (in_flat),
    .out_valid_o (bus.ValidOut),
    .out_ready_i (bus.ReadyIn),
    .out_data_o  (out_flat)
  );

  assign {bus.ResultOut, bus.Imm32Out, bus.DataOut, bus.AddrOut,
          bus.SelectorOut, head_regwrite, bus.WriteRegOut} = out_flat;

  assign out_fire    = bus.ValidOut & bus.ReadyIn;
  // Register 0 is hard-wired zero, so its writes are dropped here.
  assign bus.WbEnOut = out_fire & head_regwrite & (bus.WriteRegOut != '0);

  // A consumer that took the head during a flush still retired it.
  always_comb begin
    retired_d = retired_q;
    if (out_fire) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.RetiredOut = retired_q;

endmodule

// File: tb/tb_mawb_reg.sv
// tb/tb_mawb_reg.sv - self-checking bench for mawb_reg
module tb_mawb_reg;
  import mawb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mawb_reg_if #(.WIDTH(32), .REG_ADDR_W(5), .SEL_W(2)) bus ();

  mawb_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rdy;
    logic        fl;
    logic [31:0] res;
    logic        rw;
    logic [4:0]  wr;
    logic        ev;
    logic        er;
    logic [31:0] eres;
    logic        ewb;
    logic [31:0] eret;
  } vec_t;

  vec_t          tbl[23];
  mawb_bundle_t  mq[$];
  logic [31:0]   mret;

  function automatic vec_t mk(logic v, logic rdy, logic fl, logic [31:0] res,
                              logic rw, logic [4:0] wr, logic ev, logic er,
                              logic [31:0] eres, logic ewb, logic [31:0] eret);
    vec_t t;
    t.v = v; t.rdy = rdy; t.fl = fl; t.res = res; t.rw = rw; t.wr = wr;
    t.ev = ev; t.er = er; t.eres = eres; t.ewb = ewb; t.eret = eret;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic rdy, input logic fl, input mawb_bundle_t b);
    bus.ValidIn    = v;
    bus.ReadyIn    = rdy;
    bus.FlushIn    = fl;
    bus.ResultIn   = b.result;
    bus.Imm32In    = b.imm32;
    bus.DataIn     = b.data;
    bus.AddrIn     = b.addr;
    bus.SelectorIn = b.sel;
    bus.RegWriteIn = b.regwrite;
    bus.WriteRegIn = b.writereg;
  endtask

  function automatic mawb_bundle_t simple(logic [31:0] res, logic rw, logic [4:0] wr);
    mawb_bundle_t b;
    b.result   = res;
    b.imm32    = ~res;
    b.data     = res ^ 32'h5A5A_0000;
    b.addr     = res + 32'd4;
    b.sel      = res[1:0];
    b.regwrite = rw;
    b.writereg = wr;
    return b;
  endfunction

  // Queue model: up to two bundles held; head is mq[0].
  task automatic model_check();
    logic ev;
    logic ewb;
    ev = (mq.size() > 0);
    chk("rnd_valid", 32'(bus.ValidOut), 32'(ev));
    chk("rnd_ready", 32'(bus.ReadyOut), 32'(mq.size() < 2));
    chk("rnd_retired", bus.RetiredOut, mret);
    if (ev) begin
      chk("rnd_result", bus.ResultOut, mq[0].result);
      chk("rnd_imm", bus.Imm32Out, mq[0].imm32);
      chk("rnd_data", bus.DataOut, mq[0].data);
      chk("rnd_addr", bus.AddrOut, mq[0].addr);
      chk("rnd_sel", 32'(bus.SelectorOut), 32'(mq[0].sel));
      chk("rnd_wreg", 32'(bus.WriteRegOut), 32'(mq[0].writereg));
    end
    ewb = ev && bus.ReadyIn && mq[0].regwrite && (mq[0].writereg != 5'd0);
    chk("rnd_wben", 32'(bus.WbEnOut), 32'(ewb));
  endtask

  task automatic model_step(input mawb_bundle_t b);
    logic in_fire;
    logic out_fire;
    in_fire  = bus.ValidIn && (mq.size() < 2);
    out_fire = bus.ReadyIn && (mq.size() > 0);
    if (out_fire) begin
      void'(mq.pop_front());
      mret = mret + 32'd1;
    end
    if (bus.FlushIn) mq.delete();
    else if (in_fire) mq.push_back(b);
  endtask

  initial begin
    mawb_bundle_t b;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, simple(32'h0, 1'b0, 5'd0));

    //            v  rdy fl res       rw wr     ev er eres      wb eret
    tbl[0]  = mk(1, 1, 0, 32'h10, 1, 5'd3,  0, 1, 32'h0,  0, 32'd0);
    tbl[1]  = mk(1, 1, 0, 32'h11, 1, 5'd3,  1, 1, 32'h10, 1, 32'd0);
    tbl[2]  = mk(1, 1, 0, 32'h12, 1, 5'd3,  1, 1, 32'h11, 1, 32'd1);
    tbl[3]  = mk(1, 1, 0, 32'h13, 1, 5'd3,  1, 1, 32'h12, 1, 32'd2);
    tbl[4]  = mk(0, 1, 0, 32'h0,  1, 5'd3,  1, 1, 32'h13, 1, 32'd3);
    tbl[5]  = mk(0, 1, 0, 32'h0,  1, 5'd3,  0, 1, 32'h0,  0, 32'd4);
    tbl[6]  = mk(1, 0, 0, 32'hA0, 1, 5'd1,  0, 1, 32'h0,  0, 32'd4);
    tbl[7]  = mk(1, 0, 0, 32'hA1, 1, 5'd1,  1, 1, 32'hA0, 0, 32'd4);
    tbl[8]  = mk(1, 0, 0, 32'hA2, 1, 5'd1,  1, 0, 32'hA0, 0, 32'd4);
    tbl[9]  = mk(0, 0, 0, 32'h0,  1, 5'd1,  1, 0, 32'hA0, 0, 32'd4);
    tbl[10] = mk(0, 1, 0, 32'h0,  1, 5'd1,  1, 0, 32'hA0, 1, 32'd4);
    tbl[11] = mk(0, 1, 0, 32'h0,  1, 5'd1,  1, 1, 32'hA1, 1, 32'd5);
    tbl[12] = mk(0, 1, 0, 32'h0,  1, 5'd1,  0, 1, 32'h0,  0, 32'd6);
    tbl[13] = mk(1, 0, 0, 32'hB0, 1, 5'd2,  0, 1, 32'h0,  0, 32'd6);
    tbl[14] = mk(1, 0, 0, 32'hB1, 1, 5'd2,  1, 1, 32'hB0, 0, 32'd6);
    tbl[15] = mk(1, 0, 1, 32'hB2, 1, 5'd2,  1, 0, 32'hB0, 0, 32'd6);
    tbl[16] = mk(0, 1, 0, 32'h0,  1, 5'd2,  0, 1, 32'h0,  0, 32'd6);
    tbl[17] = mk(0, 1, 0, 32'h0,  1, 5'd2,  0, 1, 32'h0,  0, 32'd6);
    tbl[18] = mk(1, 1, 0, 32'hC0, 1, 5'd0,  0, 1, 32'h0,  0, 32'd6);
    tbl[19] = mk(1, 1, 0, 32'hC1, 1, 5'd5,  1, 1, 32'hC0, 0, 32'd6);
    tbl[20] = mk(1, 1, 0, 32'hC2, 0, 5'd5,  1, 1, 32'hC1, 1, 32'd7);
    tbl[21] = mk(0, 1, 0, 32'h0,  0, 5'd5,  1, 1, 32'hC2, 0, 32'd8);
    tbl[22] = mk(0, 1, 0, 32'h0,  0, 5'd5,  0, 1, 32'h0,  0, 32'd9);

    #1;
    chk("rst_valid", 32'(bus.ValidOut), 32'd0);
    chk("rst_ready", 32'(bus.ReadyOut), 32'd1);
    chk("rst_wben", 32'(bus.WbEnOut), 32'd0);
    chk("rst_result", bus.ResultOut, 32'd0);
    chk("rst_retired", bus.RetiredOut, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].v, tbl[i].rdy, tbl[i].fl, simple(tbl[i].res, tbl[i].rw, tbl[i].wr));
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(bus.ValidOut), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.ReadyOut), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_wben", i), 32'(bus.WbEnOut), 32'(tbl[i].ewb));
      chk($sformatf("tbl%0d_retired", i), bus.RetiredOut, tbl[i].eret);
      if (tbl[i].ev) chk($sformatf("tbl%0d_result", i), bus.ResultOut, tbl[i].eres);
      @(negedge clk);
    end

    // Asynchronous reset while two entries are held.
    drive(1'b1, 1'b0, 1'b0, simple(32'hD0, 1'b1, 5'd4));
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, simple(32'hD1, 1'b1, 5'd4));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, simple(32'h0, 1'b0, 5'd0));
    #1;
    chk("two_ready", 32'(bus.ReadyOut), 32'd0);
    chk("two_retired", bus.RetiredOut, 32'd9);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.ValidOut), 32'd0);
    chk("arst_ready", 32'(bus.ReadyOut), 32'd1);
    chk("arst_retired", bus.RetiredOut, 32'd0);
    chk("arst_result", bus.ResultOut, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, simple(32'hE0, 1'b1, 5'd6));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, simple(32'h0, 1'b0, 5'd0));
    #1;
    chk("post_rst_valid", 32'(bus.ValidOut), 32'd1);
    chk("post_rst_result", bus.ResultOut, 32'hE0);

    // Counter wrap from a preloaded value.
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    #1;
    chk("preload", bus.RetiredOut, 32'hFFFF_FFFE);
    drive(1'b1, 1'b1, 1'b0, simple(32'hE1, 1'b1, 5'd6));
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, simple(32'h0, 1'b0, 5'd0));
    #1;
    chk("wrap_max", bus.RetiredOut, 32'hFFFF_FFFF);
    chk("wrap_head", bus.ResultOut, 32'hE1);
    @(negedge clk);
    #1;
    chk("wrap_zero", bus.RetiredOut, 32'd0);
    chk("wrap_empty", 32'(bus.ValidOut), 32'd0);

    // Randomized traffic against the queue model.
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, simple(32'h0, 1'b0, 5'd0));
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    mret = 32'd0;
    for (int n = 0; n < 400; n++) begin
      b.result   = $urandom;
      b.imm32    = $urandom;
      b.data     = $urandom;
      b.addr     = $urandom;
      b.sel      = 2'($urandom_range(0, 3));
      b.regwrite = 1'($urandom_range(0, 1));
      b.writereg = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), b);
      #1;
      model_check();
      model_step(b);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mawb_reg.md
Name: mawb_reg

Overview:
- Memory-access/write-back pipeline register.
- Captures the MA-stage bundle (ALU result, 32-bit immediate, load data, link address, write-back selector, destination register, register-write enable).
- Presents that bundle to the write-back data selector and the register file.
- Uses a valid/ready handshake with a 2-entry skid buffer, so write-back stalls never create a combinational ready path back into MA.
- Supports a synchronous flush and keeps a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath width of Result/Imm32/Data/Addr.
- REG_ADDR_W, 5, register-file index width.
- SEL_W, 2, write-back selector width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- FlushIn  in  1  synchronous flush; discards all held entries.
- ValidIn  in  1  MA bundle valid.
- ReadyOut  out  1  mawb_reg can accept a bundle; driven from a register.
- ResultIn  in  WIDTH  ALU result.
- Imm32In  in  WIDTH  extended immediate.
- DataIn  in  WIDTH  memory load data.
- AddrIn  in  WIDTH  link address (PC+4/PC+8).
- SelectorIn  in  SEL_W  write-back source select.
- RegWriteIn  in  1  instruction writes the register file.
- WriteRegIn  in  REG_ADDR_W  destination register.
- ValidOut  out  1  head entry valid.
- ReadyIn  in  1  write-back consumes the head this cycle.
- ResultOut, Imm32Out, DataOut, AddrOut  out  WIDTH  head-entry fields.
- SelectorOut  out  SEL_W  head-entry selector.
- WriteRegOut  out  REG_ADDR_W  head-entry destination.
- WbEnOut  out  1  register-file write strobe.
- RetiredOut  out  32  count of bundles consumed downstream.

Behaviour:
- Handshake events:
  - In-transfer = ValidIn & ReadyOut.
  - Out-transfer = ValidOut & ReadyIn.
  - Payload is sampled only on an in-transfer.
  - ValidOut is never withdrawn and the head payload never changes while ValidOut=1 and ReadyIn=0.
- Storage:
  - Main register (head, drives all *Out fields) and skid register.
  - State = {main_v, skid_v}; skid_v=1 implies main_v=1.
  - ValidOut=main_v; ReadyOut=~skid_v.
- Transitions when FlushIn=0:
  - EMPTY (00): in-transfer -> ONE, main<=in.
  - ONE (10), in & out: stay ONE, main<=in (full throughput, 1 bundle/cycle).
  - ONE, in only: -> TWO, skid<=in.
  - ONE, out only: -> EMPTY.
  - ONE, neither: hold.
  - TWO (11): ReadyOut=0, so no in-transfer. Out-transfer -> ONE with main<=skid; else hold.
- Latency:
  - 1 cycle ValidIn->ValidOut when EMPTY.
  - Ordering is strictly FIFO and no bundle is ever duplicated or dropped, except by flush.
- Flush:
  - FlushIn=1 at an edge -> EMPTY, regardless of concurrent ValidIn/ReadyIn; the concurrent input is dropped.
  - An out-transfer in the same cycle still counts as retired, since the consumer already took it.
  - Payload registers need not be cleared.
- Write strobe:
  - WbEnOut = ValidOut & ReadyIn & RegWrite(head) & (WriteReg(head)!=0).
  - Writes to register 0 are suppressed.
- Retired counter:
  - RetiredOut increments by 1 on every out-transfer.
  - 32-bit, wraps 0xFFFFFFFF->0, no saturation.
- Reset (asynchronous, immediate):
  - main_v=skid_v=0, so ValidOut=0, ReadyOut=1, WbEnOut=0.
  - All payload outputs 0, RetiredOut=0.
  - Reset mid-transfer discards both entries.
  - First accept is possible at the first rising edge after reset deasserts.
- Selector encoding (carried untouched): 0 Result, 1 Imm32, 2 Data, 3 Addr. Values are not validated.

Decomposition:
- Package mawb_pkg:
  - Selector constants SEL_RESULT=2'd0, SEL_IMM=2'd1, SEL_DATA=2'd2, SEL_ADDR=2'd3.
  - Packed typedef mawb_bundle_t {result, imm32, data, addr, sel, regwrite, writereg}.
  - Payload width constant MAWB_W = 4*WIDTH+SEL_W+1+REG_ADDR_W.
- Sub-module skid_buf2:
  - Generic 2-entry skid buffer on a flat payload of width W with flush.
  - mawb_reg wraps it and adds the write strobe and retired counter.

Test Plan:
- Reset then stream: reset pulse, then ValidIn=1 for 4 cycles with Result=0x10..0x13, ReadyIn=1 -> ValidOut from cycle 1, ResultOut 0x10,0x11,0x12,0x13 on consecutive cycles, RetiredOut=4.
- Backpressure: ReadyIn=0 while sending 0xA0, 0xA1 -> ReadyOut drops after the second accept and ResultOut holds 0xA0. Then ReadyIn=1 -> 0xA0 then 0xA1 delivered, ReadyOut returns to 1.
- Flush in TWO state: hold 0xB0/0xB1 with ReadyIn=0, assert FlushIn with ValidIn=1 carrying 0xB2 -> next cycle ValidOut=0, ReadyOut=1, 0xB2 never appears, RetiredOut unchanged.
- Write strobe: RegWrite=1, WriteReg=0 -> WbEnOut=0. RegWrite=1, WriteReg=5 -> WbEnOut=1 for exactly the transfer cycle. RegWrite=0, WriteReg=5 -> 0.
- Asynchronous reset mid-operation: with TWO held, assert reset between clock edges -> ValidOut=0, ReadyOut=1, RetiredOut=0 immediately, without waiting for an edge.
- Counter wrap: force RetiredOut to 0xFFFFFFFF via 0xFFFFFFFF transfers (or a bench-only preload), one more out-transfer -> RetiredOut=0.
